// File: rtl/evict_buffer_pkg.sv
// Shared LC-3b types for the eviction write buffer: word/block/tag widths and FSM state encoding.
package evict_buffer_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;
  typedef logic [11:0]  lc3b_line_tag;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PMEM = 2'd1,
    WR_PMEM = 2'd2,
    RESP    = 2'd3
  } evict_state_t;

endpackage

// File: rtl/evict_buffer_if.sv
// Line-granular read/write/resp memory handshake, used on both the cache side and the pmem side.
interface evict_buffer_if;
  import evict_buffer_pkg::*;

  logic      read;
  logic      write;
  lc3b_word  address;
  lc3b_block wdata;
  lc3b_block rdata;
  logic      resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);

endinterface

// File: rtl/evict_buffer_control.sv
// Eviction buffer FSM: sequences forward hits, refill reads, victim capture and drains.
// EVICT_BUFFER_FORWARD_EN selects forwarding of buffered data on a tag hit.
module evict_buffer_control
  import evict_buffer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_hit,
  input  logic i_buf_valid,
  input  logic i_read,
  input  logic i_write,
  input  logic i_pmem_resp,
  output logic o_load_buf,
  output logic o_load_rdata_buf,
  output logic o_load_rdata_pmem,
  output logic o_clear_valid,
  output logic o_pmem_read,
  output logic o_pmem_write,
  output logic o_cache_resp
);

  evict_state_t r_state;
  evict_state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    o_load_buf        = 1'b0;
    o_load_rdata_buf  = 1'b0;
    o_load_rdata_pmem = 1'b0;
    o_clear_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        // Read has priority over write, even when both are (illegally) asserted.
        if (i_read) begin
`ifdef EVICT_BUFFER_FORWARD_EN
          if (i_hit) begin
            o_load_rdata_buf = 1'b1;
            w_next           = RESP;
          end else begin
            w_next = RD_PMEM;
          end
`else
          // Without forwarding, a hit must be written back before memory can be read.
          w_next = i_hit ? WR_PMEM : RD_PMEM;
`endif
        end else if (i_write) begin
          if (!i_buf_valid) begin
            o_load_buf = 1'b1;
            w_next     = RESP;
          end else begin
            w_next = WR_PMEM;
          end
        end else if (i_buf_valid) begin
          w_next = WR_PMEM;
        end
      end
      RD_PMEM: begin
        if (i_pmem_resp) begin
          o_load_rdata_pmem = 1'b1;
          w_next            = RESP;
        end
      end
      WR_PMEM: begin
        if (i_pmem_resp) begin
          o_clear_valid = 1'b1;
          w_next        = IDLE;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign o_pmem_read  = (r_state == RD_PMEM);
  assign o_pmem_write = (r_state == WR_PMEM);
  assign o_cache_resp = (r_state == RESP);

endmodule

// File: rtl/evict_buffer.sv
// Single-entry victim write buffer between the LC-3b cache and physical memory.
// Forwarding of buffered data on read hits is enabled by EVICT_BUFFER_FORWARD_EN.
module evict_buffer
  import evict_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  evict_buffer_if.slave  cache,
  evict_buffer_if.master pmem
);

  logic         r_buf_valid;
  lc3b_line_tag r_buf_tag;
  lc3b_block    r_buf_data;
  lc3b_block    r_rdata;

  logic w_hit;
  logic w_load_buf;
  logic w_load_rdata_buf;
  logic w_load_rdata_pmem;
  logic w_clear_valid;
  logic w_pmem_read;
  logic w_pmem_write;
  logic w_cache_resp;

  assign w_hit = r_buf_valid && (cache.address[15:4] == r_buf_tag);

  evict_buffer_control u_control (
    .clk               (clk),
    .reset             (reset),
    .i_hit             (w_hit),
    .i_buf_valid       (r_buf_valid),
    .i_read            (cache.read),
    .i_write           (cache.write),
    .i_pmem_resp       (pmem.resp),
    .o_load_buf        (w_load_buf),
    .o_load_rdata_buf  (w_load_rdata_buf),
    .o_load_rdata_pmem (w_load_rdata_pmem),
    .o_clear_valid     (w_clear_valid),
    .o_pmem_read       (w_pmem_read),
    .o_pmem_write      (w_pmem_write),
    .o_cache_resp      (w_cache_resp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_load_buf) begin
        r_buf_valid <= 1'b1;
        r_buf_tag   <= cache.address[15:4];
        r_buf_data  <= cache.wdata;
      end else if (w_clear_valid) begin
        r_buf_valid <= 1'b0;
      end
      if (w_load_rdata_buf)       r_rdata <= r_buf_data;
      else if (w_load_rdata_pmem) r_rdata <= pmem.rdata;
    end
  end

  assign cache.rdata  = r_rdata;
  assign cache.resp   = w_cache_resp;
  assign pmem.read    = w_pmem_read;
  assign pmem.write   = w_pmem_write;
  // Address and data are zero outside an active pmem request.
  assign pmem.address = w_pmem_read  ? {cache.address[15:4], 4'h0} :
                         w_pmem_write ? {r_buf_tag, 4'h0} : 16'h0000;
  assign pmem.wdata    = w_pmem_write ? r_buf_data : '0;

endmodule
